// File: rtl/neosd_dat_ctrl.sv
// ============================================================================
//  neosd_dat_ctrl : SD DAT-line transfer sequencer with read-word FIFO
//  Revision 1.0
// ============================================================================
`default_nettype none

module neosd_dat_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int BLK_W      = 16
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             clkstrb_i,
   input  logic             xfer_start_i,
   input  logic             xfer_abort_i,
   input  logic [1:0]       xfer_dmode_i,
   input  logic [BLK_W-1:0] xfer_blocks_i,
   output logic             xfer_busy_o,
   output logic             xfer_done_o,
   output logic             xfer_crc_err_o,
   output logic             xfer_aborted_o,
   output logic [BLK_W-1:0] xfer_blocks_done_o,
   output logic [31:0]      rd_data_o,
   output logic             rd_valid_o,
   input  logic             rd_ready_i,
   output logic             dat_start_o,
   output logic             dat_ack_o,
   output logic             dat_last_block_o,
   output logic [1:0]       dat_dmode_o,
   input  logic             dat_idle_i,
   input  logic             dat_data_i,
   input  logic             dat_block_done_i,
   input  logic             dat_crc_ok_i,
   input  logic [31:0]      dat_word_i
);

   localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);

   localparam logic [1:0] c_DM_NONE  = 2'd0;
   localparam logic [1:0] c_DM_BUSY  = 2'd1;
   localparam logic [1:0] c_DM_READ  = 2'd2;
   localparam logic [1:0] c_DM_WRITE = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_RUN   = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [1:0]          r_dmode;
   logic [BLK_W-1:0]    r_blocks;
   logic [BLK_W-1:0]    r_blocks_done;
   logic                r_crc_err;
   logic                r_aborted;
   logic                r_done;

   logic [31:0]         r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0]  r_wptr;
   logic [c_PTR_W-1:0]  r_rptr;
   logic [c_CNT_W-1:0]  r_count;

   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic                w_blk_evt;
   logic [BLK_W-1:0]    w_blk_done_p1;
   logic                w_start_acc;
   logic                w_done_nxt;
   logic                w_blk_inc;
   logic                w_crc_fail;
   logic                w_abort_set;

   assign w_full        = (r_count == c_FULL);
   assign w_empty       = (r_count == '0);
   // Ack is combinational so the DAT FSM sees it on the very strobe it samples.
   assign w_push        = clkstrb_i & dat_data_i & ~w_full;
   assign w_pop         = rd_ready_i & ~w_empty;
   assign w_blk_evt     = clkstrb_i & dat_block_done_i;
   assign w_blk_done_p1 = r_blocks_done + BLK_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_start_acc = 1'b0;
      w_done_nxt  = 1'b0;
      w_blk_inc   = 1'b0;
      w_crc_fail  = 1'b0;
      w_abort_set = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (xfer_start_i) begin
               w_start_acc = 1'b1;
               if ((xfer_dmode_i == c_DM_BUSY) ||
                   ((xfer_dmode_i == c_DM_READ) && (xfer_blocks_i != '0))) begin
                  w_state_nxt = S_START;
               end else begin
                  w_done_nxt = 1'b1;
               end
               if (xfer_dmode_i == c_DM_WRITE) begin
                  w_abort_set = 1'b1;
               end
            end
         end
         S_START: begin
            if (xfer_abort_i) begin
               w_abort_set = 1'b1;
               w_state_nxt = S_STOP;
            end else if (!dat_idle_i) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (r_dmode == c_DM_READ) begin
               if (w_blk_evt) begin
                  if (dat_crc_ok_i) begin
                     w_blk_inc = (r_blocks_done != r_blocks);
                     if ((w_blk_done_p1 == r_blocks) || (r_blocks_done == r_blocks)) begin
                        w_state_nxt = S_STOP;
                     end
                  end else begin
                     w_crc_fail  = 1'b1;
                     w_state_nxt = S_STOP;
                  end
               end
            end else if (dat_idle_i) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
            // A block finishing in the abort cycle is still counted above.
            if (xfer_abort_i) begin
               w_abort_set = 1'b1;
               w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (dat_idle_i) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state       <= S_IDLE;
         r_dmode       <= c_DM_NONE;
         r_blocks      <= '0;
         r_blocks_done <= '0;
         r_crc_err     <= 1'b0;
         r_aborted     <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_done_nxt;
         if (w_start_acc) begin
            r_dmode       <= xfer_dmode_i;
            r_blocks      <= xfer_blocks_i;
            r_blocks_done <= '0;
            r_crc_err     <= 1'b0;
            r_aborted     <= 1'b0;
         end
         if (w_blk_inc) begin
            r_blocks_done <= w_blk_done_p1;
         end
         if (w_crc_fail) begin
            r_crc_err <= 1'b1;
         end
         if (w_abort_set) begin
            r_aborted <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (w_start_acc) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + c_PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wptr] <= dat_word_i;
      end
   end

   assign xfer_busy_o        = (r_state != S_IDLE);
   assign xfer_done_o        = r_done;
   assign xfer_crc_err_o     = r_crc_err;
   assign xfer_aborted_o     = r_aborted;
   assign xfer_blocks_done_o = r_blocks_done;
   assign rd_valid_o         = ~w_empty;
   assign rd_data_o          = w_empty ? 32'd0 : r_mem[r_rptr];
   assign dat_start_o        = (r_state == S_START) & dat_idle_i;
   assign dat_ack_o          = w_push;
   assign dat_last_block_o   = (r_state == S_STOP);
   assign dat_dmode_o        = r_dmode;

endmodule

`default_nettype wire
